// File: rtl/fetch_pkg.sv
// Shared constants and FIFO entry type for the instruction fetch unit.
// FETCH_PREDECODE_EN adds per-entry predecode flags to the entry type.
package fetch_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

`ifdef FETCH_PREDECODE_EN
  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_alu;
    logic illegal;
  } pdec_t;

  function automatic pdec_t predecode(input logic [31:0] w);
    pdec_t p;
    p.is_load  = (w[6:0] == OPC_LOAD);
    p.is_store = (w[6:0] == OPC_STORE);
    p.is_alu   = (w[6:0] == OPC_OP) || (w[6:0] == OPC_OPIMM);
    p.illegal  = (w[1:0] != 2'b11) || !(p.is_load || p.is_store || p.is_alu);
    return p;
  endfunction
`endif

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
`ifdef FETCH_PREDECODE_EN
    pdec_t           pd;
`endif
  } entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory, decoder and redirect signals of the fetch unit.
// FETCH_PREDECODE_EN adds the predecode flag outputs.
interface instr_fetch_if #(parameter int XLEN = 64);
  logic            imem_en;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
`ifdef FETCH_PREDECODE_EN
  logic            instr_is_load;
  logic            instr_is_store;
  logic            instr_is_alu;
  logic            instr_illegal;
`endif

  modport master (
    input  imem_rdata, instr_ready, redirect_valid, redirect_pc,
`ifdef FETCH_PREDECODE_EN
    output instr_is_load, instr_is_store, instr_is_alu, instr_illegal,
`endif
    output imem_en, imem_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output imem_rdata, instr_ready, redirect_valid, redirect_pc,
`ifdef FETCH_PREDECODE_EN
    input  instr_is_load, instr_is_store, instr_is_alu, instr_illegal,
`endif
    input  imem_en, imem_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with a registered head copy; flush empties it in one cycle.
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output T              head,
  output logic          head_vld
);

  T               mem [DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]  rest, count_nxt;
  T               head_nxt;

  // Entries left after the pop decide whether the new head comes from
  // storage or is the word being pushed right now.
  always_comb begin
    rd_nxt    = rd_ptr + AW'(pop);
    rest      = count - CW'(pop);
    count_nxt = rest + CW'(push);
    head_nxt  = head;
    if (rest != '0)  head_nxt = mem[rd_nxt];
    else if (push)   head_nxt = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      head_vld <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      head_vld <= 1'b0;
    end else begin
      rd_ptr   <= rd_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      count    <= count_nxt;
      head     <= head_nxt;
      head_vld <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (pop || count < CW'(DEPTH)));
`endif

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, request issue to a 1-cycle imem, squash on redirect.
// FETCH_PREDECODE_EN adds load/store/alu/illegal flags aligned with instr.
module instr_fetch #(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  bus
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc, resp_pc;
  logic            inflight;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            pop, push, issue;
  entry_t          wentry, head;
  logic            head_vld;

  assign pop = head_vld & bus.instr_ready;

  // Slots already committed (stored + in flight) after this cycle's pop.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = rst_n & ~bus.redirect_valid & (occ < (CW+1)'(DEPTH));
  assign push  = inflight & ~bus.redirect_valid;

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) resp_pc <= fetch_pc;
      if (bus.redirect_valid) fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (issue)         fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  always_comb begin
    wentry       = '0;
    wentry.instr = bus.imem_rdata;
    wentry.pc    = resp_pc;
`ifdef FETCH_PREDECODE_EN
    wentry.pd    = predecode(bus.imem_rdata);
`endif
  end

  fetch_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .wdata    (wentry),
    .pop      (pop),
    .flush    (bus.redirect_valid),
    .count    (count),
    .head     (head),
    .head_vld (head_vld)
  );

  assign bus.instr_valid = head_vld;
  assign bus.instr       = head.instr;
  assign bus.instr_pc    = head.pc;
`ifdef FETCH_PREDECODE_EN
  assign bus.instr_is_load  = head.pd.is_load;
  assign bus.instr_is_store = head.pd.is_store;
  assign bus.instr_is_alu   = head.pd.is_alu;
  assign bus.instr_illegal  = head.pd.illegal;
`endif

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit feeding the RV64 decode/execute datapath. It owns the program counter and issues word reads to a 1-cycle-latency synchronous instruction memory. Fetched words are buffered in a small prefetch FIFO and handed to the decoder over a valid/ready handshake together with their PC. A redirect input flushes the pipeline and restarts fetch at a new address.

## Interface
Parameters:
- XLEN, 64, PC / address width
- RESET_PC, 0, first fetch address after reset
- DEPTH, 4, prefetch FIFO entries (power of 2, ≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; **single clock, asynchronous, active-low**
- imem_en  out  1  read request this cycle
- imem_addr  out  XLEN  word address of the request (bits [1:0] always 0)
- imem_rdata  in  32  read data, valid the cycle after imem_en
- instr_valid  out  1  FIFO head valid
- instr  out  32  instruction word at FIFO head
- instr_pc  out  XLEN  PC of instr
- instr_ready  in  1  decoder accepts head
- redirect_valid  in  1  restart fetch
- redirect_pc  in  XLEN  restart address (bits [1:0] ignored)

## Operation
- State: fetch_pc; FIFO (count 0..DEPTH); inflight flag (0/1).
- Pop = instr_valid & instr_ready.
- Issue rule: imem_en = rst_n & !redirect_valid & (count + inflight − pop < DEPTH).
  - On issue, imem_addr = fetch_pc, fetch_pc += 4 (wraps mod 2^XLEN), inflight set for next cycle.
- Response: when inflight is set, {imem_rdata, issued PC} is pushed at the clock edge unless squashed.
- Push and pop in the same cycle are legal at any count; count is unchanged.
- Overflow is impossible by the issue rule; a push into a full FIFO is an assertion failure.
- Redirect (highest priority): at the edge
  - FIFO emptied
  - a pending response is squashed and never enters the FIFO
  - fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}
  - A pop in the redirect cycle still counts as consumed by the decoder.
  - Back-to-back redirects: the last one wins.
- Reset mid-operation: all state is cleared asynchronously. Any memory response arriving after the rst_n release edge is ignored (inflight = 0).

## Timing
- Reset values: instr_valid 0, instr 0, instr_pc 0, imem_en 0, imem_addr RESET_PC, fetch_pc RESET_PC, count 0, inflight 0.
- First cycle after rst_n release: imem_en=1, imem_addr=RESET_PC.
- Issue-to-instr_valid latency is 2 cycles: request in cycle t, data in t+1, visible at the head in t+2.
- Sustained throughput is 1 instruction/cycle with instr_ready held high.
- Redirect in cycle t: imem_en=0 in t; request to the target in t+1; target instr_valid in t+3.
- instr, instr_pc, and instr_valid are registered FIFO outputs with no bypass from imem_rdata.
- instr and instr_pc are held stable while instr_valid & !instr_ready.
- imem_en is combinational from instr_ready and redirect_valid; there is no other combinational input-to-output path.

## Configuration
- FETCH_PREDECODE_EN defined:
  - Adds outputs instr_is_load, instr_is_store, instr_is_alu, instr_illegal, each 1 bit, stored per FIFO entry and aligned with instr.
  - load = opcode 0000011; store = 0100011; alu = 0110011 or 0010011.
  - illegal = instr[1:0] != 2'b11 or an opcode outside those four.
  - All four outputs reset to 0.
- Not defined: these ports and their storage do not exist; behaviour is otherwise identical.

## Structure
- Package fetch_pkg:
  - XLEN default
  - opcode constants OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM
  - entry typedef {instr, pc[, predecode bits]}
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO with push, pop, flush, count, and registered head.
- The PC, issue, and squash logic live in instr_fetch.

## Test plan
- Reset release, RESET_PC=0x100, ready=1, memory word = address → imem_addr 0x100,0x104,0x108…; instr_valid rises 2 cycles after release; instr=0x100, instr_pc=0x100, then one per cycle.
- ready=0 from start, DEPTH=4 → exactly 4 requests issued, then imem_en stays 0; after ready=1, instructions 0x100..0x10C pop in order with no loss or duplicate.
- Redirect to 0x203 at the 3rd pop while a response is in flight → squashed word never appears; the next valid instr_pc is 0x200, 3 cycles later.
- fetch_pc=2^64−4 → the next request address is 0x0 (wrap) with no stall.
- rst_n pulsed low mid-stream with a response in flight → instr_valid 0 immediately; after release, the first instr_pc is RESET_PC.
- FETCH_PREDECODE_EN with words 0x00003083 (ld), 0x00113023 (sd), 0x00100093 (addi), 0x00000000 → flags load, store, alu, illegal respectively.
